// File: rtl/spike_rate_encoder.sv
// Rate-coding front end: latches one frame of pixel intensities, then emits
// WINDOW timesteps of per-channel Bernoulli spikes driven by 16-bit LFSRs.
module spike_rate_encoder #(
    parameter int unsigned INPUTNUM = 10,
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned WINDOW   = 16,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      abort,
    input  logic                      pix_valid,
    output logic                      pix_ready,
    input  logic [INPUTNUM*PIX_W-1:0] pix_data,
    output logic [INPUTNUM-1:0]       spikes_out,
    output logic                      spike_valid,
    output logic                      frame_done,
    output logic                      busy
);
    localparam int unsigned    SCW       = $clog2(WINDOW + 1);
    localparam logic [SCW-1:0] LAST_STEP = SCW'(WINDOW - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                    r_state;
    logic [INPUTNUM*PIX_W-1:0] r_pix;
    logic [SCW-1:0]            r_step;
    logic [15:0]               r_lfsr [INPUTNUM];
    logic [INPUTNUM-1:0]       r_spikes;
    logic                      r_spike_valid;
    logic                      r_frame_done;
    logic                      r_pix_ready;
    logic                      r_busy;

    logic [15:0]               w_lfsr_nxt [INPUTNUM];
    logic [INPUTNUM-1:0]       w_spk;

    // A seed that would collapse to zero locks the LFSR, so substitute 1.
    function automatic logic [15:0] seed_of(input int unsigned j);
        logic [15:0] s;
        s = SEED ^ 16'(j);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    for (genvar g = 0; g < INPUTNUM; g++) begin : g_ch
        logic [PIX_W-1:0] w_pix;
        logic [PIX_W-1:0] w_rnd;
        assign w_pix          = r_pix[g*PIX_W +: PIX_W];
        assign w_rnd          = r_lfsr[g][15 -: PIX_W];
        assign w_spk[g]       = (w_pix == '1) || (w_rnd < w_pix);
        assign w_lfsr_nxt[g]  = {r_lfsr[g][14:0],
                                 r_lfsr[g][15] ^ r_lfsr[g][13] ^ r_lfsr[g][12] ^ r_lfsr[g][10]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pix         <= '0;
            r_step        <= '0;
            r_spikes      <= '0;
            r_spike_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_pix_ready   <= 1'b1;
            r_busy        <= 1'b0;
            for (int unsigned j = 0; j < INPUTNUM; j++) begin
                r_lfsr[j] <= seed_of(j);
            end
        end else begin
            r_spikes      <= '0;
            r_spike_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pix_valid) begin
                        r_pix       <= pix_data;
                        r_step      <= '0;
                        r_state     <= S_RUN;
                        r_pix_ready <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_pix_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (en) begin
                        r_spikes      <= w_spk;
                        r_spike_valid <= 1'b1;
                        r_step        <= r_step + 1'b1;
                        for (int unsigned j = 0; j < INPUTNUM; j++) begin
                            r_lfsr[j] <= w_lfsr_nxt[j];
                        end
                        if (r_step == LAST_STEP) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                            r_pix_ready  <= 1'b1;
                            r_busy       <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_pix_ready <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign spikes_out  = r_spikes;
    assign spike_valid = r_spike_valid;
    assign frame_done  = r_frame_done;
    assign pix_ready   = r_pix_ready;
    assign busy        = r_busy;
endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: vector table for the first timesteps
// after reset, plus sequences for stall, abort, back-to-back and async reset.
module tb_spike_rate_encoder;
    localparam int N  = 10;
    localparam int PW = 8;
    localparam int W  = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            en = 1'b0;
    logic            abort = 1'b0;
    logic            pix_valid = 1'b0;
    logic            pix_ready;
    logic [N*PW-1:0] pix_data = '0;
    logic [N-1:0]    spikes_out;
    logic            spike_valid;
    logic            frame_done;
    logic            busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spike_rate_encoder #(
        .INPUTNUM (N),
        .PIX_W    (PW),
        .WINDOW   (W),
        .SEED     (16'hACE1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .abort       (abort),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .spikes_out  (spikes_out),
        .spike_valid (spike_valid),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    // Reference LFSR state and latched frame, advanced only on timesteps.
    logic [15:0]     m_lfsr [N];
    logic [N*PW-1:0] m_pix;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset;
        for (int j = 0; j < N; j++) begin
            m_lfsr[j] = 16'hACE1 ^ 16'(j);
            if (m_lfsr[j] == 16'h0000) m_lfsr[j] = 16'h0001;
        end
    endtask

    task automatic m_step;
        for (int j = 0; j < N; j++) begin
            m_lfsr[j] = {m_lfsr[j][14:0],
                         m_lfsr[j][15] ^ m_lfsr[j][13] ^ m_lfsr[j][12] ^ m_lfsr[j][10]};
        end
    endtask

    function automatic logic [N-1:0] m_spikes();
        logic [N-1:0]  s;
        logic [PW-1:0] p;
        logic [PW-1:0] r;
        s = '0;
        for (int j = 0; j < N; j++) begin
            p    = m_pix[j*PW +: PW];
            r    = m_lfsr[j][15 -: PW];
            s[j] = (p == 8'hFF) || (r < p);
        end
        return s;
    endfunction

    task automatic do_reset;
        rst_n     = 1'b0;
        en        = 1'b0;
        abort     = 1'b0;
        pix_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic send_frame(input logic [N*PW-1:0] d);
        int guard;
        guard = 0;
        while (!pix_ready && guard < 50) begin
            tick;
            guard++;
        end
        chk("send_ready", 32'(pix_ready), 32'd1);
        pix_data  = d;
        pix_valid = 1'b1;
        tick;
        pix_valid = 1'b0;
        m_pix     = d;
    endtask

    typedef struct {
        logic [N*PW-1:0] pix;
        logic [N-1:0]    e0;
        logic [N-1:0]    e1;
        logic [N-1:0]    e2;
    } vec_t;

    vec_t vecs [6];

    localparam logic [N*PW-1:0] ALL80 = {10{8'h80}};
    localparam logic [N*PW-1:0] MIX   = 80'h0000000000_FEB3B4595A;
    localparam logic [N*PW-1:0] CH0AD = {72'h0, 8'hAD};

    initial begin
        logic [N-1:0] exp;
        int           cnt;
        int           k;
        int           gap;
        logic         e;

        // Every channel's LFSR top byte runs 0xAC, 0x59, 0xB3 for the first three steps.
        vecs[0] = '{pix: ALL80,              e0: 10'h000, e1: 10'h3FF, e2: 10'h000};
        vecs[1] = '{pix: '0,                 e0: 10'h000, e1: 10'h000, e2: 10'h000};
        vecs[2] = '{pix: {10{8'hFF}},        e0: 10'h3FF, e1: 10'h3FF, e2: 10'h3FF};
        vecs[3] = '{pix: {72'h0, 8'hAC},     e0: 10'h000, e1: 10'h001, e2: 10'h000};
        vecs[4] = '{pix: CH0AD,              e0: 10'h001, e1: 10'h001, e2: 10'h000};
        vecs[5] = '{pix: MIX,                e0: 10'h01C, e1: 10'h01D, e2: 10'h014};

        // Reset state
        tick;
        chk("rst_pix_ready", 32'(pix_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_spike_valid", 32'(spike_valid), 32'd0);
        chk("rst_spikes", 32'(spikes_out), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);

        // Table: first three timesteps after reset
        for (int i = 0; i < 6; i++) begin
            do_reset;
            send_frame(vecs[i].pix);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
            en = 1'b1;
            for (int s = 0; s < 3; s++) begin
                tick;
                chk($sformatf("vec%0d_valid%0d", i, s), 32'(spike_valid), 32'd1);
                case (s)
                    0: exp = vecs[i].e0;
                    1: exp = vecs[i].e1;
                    default: exp = vecs[i].e2;
                endcase
                chk($sformatf("vec%0d_spk%0d", i, s), 32'(spikes_out), 32'(exp));
            end
            en = 1'b0;
        end

        // Full frame, pix_valid held with different data during RUN
        do_reset;
        send_frame(ALL80);
        pix_data  = {10{8'hFF}};
        pix_valid = 1'b1;
        en        = 1'b1;
        for (int s = 0; s < W; s++) begin
            if (s == W - 1) pix_valid = 1'b0;
            exp = m_spikes();
            tick;
            m_step();
            chk($sformatf("full_valid%0d", s), 32'(spike_valid), 32'd1);
            chk($sformatf("full_spk%0d", s), 32'(spikes_out), 32'(exp));
            chk($sformatf("full_done%0d", s), 32'(frame_done), 32'(s == W - 1));
            if (s < W - 1) chk($sformatf("full_ready%0d", s), 32'(pix_ready), 32'd0);
        end
        tick;
        chk("full_after_ready", 32'(pix_ready), 32'd1);
        chk("full_after_busy", 32'(busy), 32'd0);
        chk("full_after_valid", 32'(spike_valid), 32'd0);
        chk("full_after_done", 32'(frame_done), 32'd0);
        en = 1'b0;

        // Stalled enable 1,0,0,1,...
        do_reset;
        send_frame(MIX);
        cnt = 0;
        k   = 0;
        while (cnt < W && k < 200) begin
            e   = (k % 3 == 0);
            en  = e;
            exp = m_spikes();
            tick;
            if (e) begin
                cnt++;
                m_step();
                chk($sformatf("stall_valid%0d", k), 32'(spike_valid), 32'd1);
                chk($sformatf("stall_spk%0d", k), 32'(spikes_out), 32'(exp));
                chk($sformatf("stall_done%0d", k), 32'(frame_done), 32'(cnt == W));
            end else begin
                chk($sformatf("stall_idle_valid%0d", k), 32'(spike_valid), 32'd0);
                chk($sformatf("stall_idle_spk%0d", k), 32'(spikes_out), 32'd0);
                chk($sformatf("stall_idle_done%0d", k), 32'(frame_done), 32'd0);
            end
            k++;
        end
        chk("stall_steps", 32'(cnt), 32'(W));
        en = 1'b0;

        // Abort at step 5, then a frame continuing the LFSR sequence
        do_reset;
        send_frame(ALL80);
        en = 1'b1;
        for (int s = 0; s < 5; s++) begin
            exp = m_spikes();
            tick;
            m_step();
            chk($sformatf("abort_pre_spk%0d", s), 32'(spikes_out), 32'(exp));
        end
        abort = 1'b1;
        tick;
        abort = 1'b0;
        en    = 1'b0;
        chk("abort_valid", 32'(spike_valid), 32'd0);
        chk("abort_done", 32'(frame_done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(pix_ready), 32'd1);
        tick;
        chk("abort_no_done", 32'(frame_done), 32'd0);
        send_frame(MIX);
        en = 1'b1;
        for (int s = 0; s < W; s++) begin
            exp = m_spikes();
            tick;
            m_step();
            chk($sformatf("cont_spk%0d", s), 32'(spikes_out), 32'(exp));
            chk($sformatf("cont_done%0d", s), 32'(frame_done), 32'(s == W - 1));
        end

        // Back-to-back frames with pix_valid held
        pix_data  = ALL80;
        pix_valid = 1'b1;
        tick;
        k = 0;
        while (!frame_done && k < 40) begin
            tick;
            k++;
        end
        chk("b2b_done_seen", 32'(frame_done), 32'd1);
        chk("b2b_ready_at_done", 32'(pix_ready), 32'd1);
        gap = 0;
        do begin
            tick;
            gap++;
        end while (!spike_valid && gap < 10);
        chk("b2b_gap", 32'(gap), 32'd2);
        pix_valid = 1'b0;
        en        = 1'b0;

        // Asynchronous reset mid-frame, then replay of the seed threshold case
        do_reset;
        send_frame(CH0AD);
        en = 1'b1;
        for (int s = 0; s < 7; s++) tick;
        chk("arst_pre_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(pix_ready), 32'd1);
        chk("arst_valid", 32'(spike_valid), 32'd0);
        chk("arst_spikes", 32'(spikes_out), 32'd0);
        chk("arst_done", 32'(frame_done), 32'd0);
        #2;
        rst_n = 1'b1;
        en    = 1'b0;
        m_reset();
        send_frame(CH0AD);
        en = 1'b1;
        tick;
        chk("arst_replay_valid", 32'(spike_valid), 32'd1);
        chk("arst_replay_spk", 32'(spikes_out), 32'h001);
        en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
